// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - SPI register map, flash command bytes and boot FSM encoding.
package spi_pkg;

    localparam logic [31:0] SPI_REG_TX   = 32'd0;
    localparam logic [31:0] SPI_REG_DIV  = 32'd4;
    localparam logic [31:0] SPI_REG_RX   = 32'd8;
    localparam logic [31:0] SPI_REG_BUSY = 32'd12;
    localparam logic [31:0] SPI_REG_CS   = 32'd16;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam logic [7:0] FLASH_DUMMY    = 8'hFF;

    typedef enum logic [3:0] {
        ST_SET_DIV,
        ST_CS_LO,
        ST_TX,
        ST_WAIT0,
        ST_WAIT,
        ST_RX_REQ,
        ST_RX_CAP,
        ST_MEM_WR,
        ST_CS_HI,
        ST_DONE
    } boot_state_e;

    // Byte shifted out for transfer idx: READ opcode, 24-bit address MSB first, then dummies.
    function automatic logic [7:0] header_byte(input logic [2:0] idx, input logic [23:0] base);
        case (idx)
            3'd0:    return FLASH_CMD_READ;
            3'd1:    return base[23:16];
            3'd2:    return base[15:8];
            3'd3:    return base[7:0];
            default: return FLASH_DUMMY;
        endcase
    endfunction

endpackage

// File: rtl/spi_boot_seq_if.sv
// rtl/spi_boot_seq_if.sv - SPI register-port bus (write strobe, address, data, read data).
interface spi_boot_seq_if;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output wen, output addr, output wdata, input rdata);
    modport slave  (input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/spi_boot_seq_mux.sv
// rtl/spi_boot_seq_mux.sv - SPI register-port ownership mux between sequencer and CPU.
module spi_boot_seq_mux (
    input  logic            own_cpu,
    input  logic            seq_wen,
    input  logic [31:0]     seq_addr,
    input  logic [31:0]     seq_wdata,
    spi_boot_seq_if.slave   cpu,
    spi_boot_seq_if.master  spi
);

    assign spi.wen   = own_cpu ? cpu.wen   : seq_wen;
    assign spi.addr  = own_cpu ? cpu.addr  : seq_addr;
    assign spi.wdata = own_cpu ? cpu.wdata : seq_wdata;

    // The CPU sees nothing from the controller until the boot copy has released the port.
    assign cpu.rdata = own_cpu ? spi.rdata : 32'h0;

endmodule

// File: rtl/spi_boot_seq.sv
// rtl/spi_boot_seq.sv - boot sequencer: copies a flash image into RAM over SPI, then
// hands the SPI register port to the CPU and releases it from hold.
module spi_boot_seq
    import spi_pkg::*;
#(
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter logic [31:0] BOOT_LEN   = 32'd4096,
    parameter logic [31:0] RAM_BASE   = 32'h00000000,
    parameter logic [31:0] CLK_DIV    = 32'd1
) (
    input  logic            clk,
    input  logic            reset,
    spi_boot_seq_if.slave   cpu,
    spi_boot_seq_if.master  spi,
    output logic            mem_wen,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic            cpu_hold,
    output logic            boot_done
);

    boot_state_e state_q, state_d;
    logic [2:0]  hdr_cnt_q, hdr_cnt_d;
    logic        tx_hdr_q, tx_hdr_d;
    logic [31:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;
    logic        boot_done_q, boot_done_d;
    logic        cpu_hold_q, cpu_hold_d;

    logic        seq_wen;
    logic [31:0] seq_addr;
    logic [31:0] seq_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SET_DIV;
            hdr_cnt_q   <= 3'd0;
            tx_hdr_q    <= 1'b0;
            byte_cnt_q  <= 32'd0;
            word_q      <= 32'd0;
            boot_done_q <= 1'b0;
            cpu_hold_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            tx_hdr_q    <= tx_hdr_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            boot_done_q <= boot_done_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        tx_hdr_d    = tx_hdr_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        boot_done_d = boot_done_q;
        cpu_hold_d  = cpu_hold_q;
        seq_wen     = 1'b0;
        seq_addr    = 32'h0;
        seq_wdata   = 32'h0;
        mem_wen     = 1'b0;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;

        case (state_q)
            ST_SET_DIV: begin
                seq_wen   = 1'b1;
                seq_addr  = SPI_REG_DIV;
                seq_wdata = CLK_DIV;
                state_d   = (BOOT_LEN == 32'd0) ? ST_DONE : ST_CS_LO;
            end
            ST_CS_LO: begin
                seq_wen   = 1'b1;
                seq_addr  = SPI_REG_CS;
                seq_wdata = 32'd0;
                state_d   = ST_TX;
            end
            ST_TX: begin
                seq_wen   = 1'b1;
                seq_addr  = SPI_REG_TX;
                seq_wdata = {24'h0, header_byte(hdr_cnt_q, FLASH_BASE)};
                tx_hdr_d  = (hdr_cnt_q != 3'd4);
                if (hdr_cnt_q != 3'd4) begin
                    hdr_cnt_d = hdr_cnt_q + 3'd1;
                end
                state_d   = ST_WAIT0;
            end
            // Read data here still reflects the TX-register access; busy is valid next cycle.
            ST_WAIT0: begin
                seq_addr = SPI_REG_BUSY;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                seq_addr = SPI_REG_BUSY;
                if (!spi.rdata[0]) begin
                    state_d = tx_hdr_q ? ST_TX : ST_RX_REQ;
                end
            end
            ST_RX_REQ: begin
                seq_addr = SPI_REG_RX;
                state_d  = ST_RX_CAP;
            end
            ST_RX_CAP: begin
                seq_addr   = SPI_REG_RX;
                word_d     = word_q | ({24'h0, spi.rdata[7:0]} << {byte_cnt_q[1:0], 3'b000});
                byte_cnt_d = byte_cnt_q + 32'd1;
                if (byte_cnt_q[1:0] == 2'd3 || byte_cnt_q == BOOT_LEN - 32'd1) begin
                    state_d = ST_MEM_WR;
                end else begin
                    state_d = ST_TX;
                end
            end
            // byte_cnt_q already counts the last captured byte, so step back one to find its word.
            ST_MEM_WR: begin
                mem_wen   = 1'b1;
                mem_addr  = RAM_BASE + ((byte_cnt_q - 32'd1) & ~32'd3);
                mem_wdata = word_q;
                word_d    = 32'd0;
                state_d   = (byte_cnt_q == BOOT_LEN) ? ST_CS_HI : ST_TX;
            end
            ST_CS_HI: begin
                seq_wen   = 1'b1;
                seq_addr  = SPI_REG_CS;
                seq_wdata = 32'd1;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                boot_done_d = 1'b1;
                cpu_hold_d  = 1'b0;
            end
            default: begin
                state_d = ST_SET_DIV;
            end
        endcase

        // Keep both buses quiet while reset is held, even though the state sits in SET_DIV.
        if (reset) begin
            seq_wen   = 1'b0;
            seq_addr  = 32'h0;
            seq_wdata = 32'h0;
            mem_wen   = 1'b0;
            mem_addr  = 32'h0;
            mem_wdata = 32'h0;
        end
    end

    spi_boot_seq_mux u_mux (
        .own_cpu   (boot_done_q),
        .seq_wen   (seq_wen),
        .seq_addr  (seq_addr),
        .seq_wdata (seq_wdata),
        .cpu       (cpu),
        .spi       (spi)
    );

    assign boot_done = boot_done_q;
    assign cpu_hold  = cpu_hold_q;

endmodule

// File: tb/tb_spi_boot_seq.sv
// tb/tb_spi_boot_seq.sv - directed bench: four sequencer instances against an SPI
// controller plus serial-flash model.
module tb_spi_boot_seq;

    localparam int NI = 4;
    // Instance 0: full copy, slow clock. 1: partial word. 2: zero length. 3: mid-run reset.
    localparam logic [NI-1:0][31:0] LEN_T = {32'd8, 32'd0, 32'd5, 32'd8};
    localparam logic [NI-1:0][31:0] DIV_T = {32'd1, 32'd1, 32'd1, 32'd5};

    logic          clk;
    logic [NI-1:0] rst;
    logic          cpu_wen   [NI];
    logic [31:0]   cpu_addr  [NI];
    logic [31:0]   cpu_wdata [NI];

    logic          spi_wen_w   [NI];
    logic [31:0]   spi_addr_w  [NI];
    logic [31:0]   spi_wdata_w [NI];
    logic [31:0]   cpu_rdata_w [NI];
    logic          mem_wen_w   [NI];
    logic [31:0]   mem_addr_w  [NI];
    logic [31:0]   mem_wdata_w [NI];
    logic          cpu_hold_w  [NI];
    logic          boot_done_w [NI];

    logic          m_cs     [NI];
    logic          m_busy   [NI];
    int            m_cnt    [NI];
    logic [31:0]   m_div    [NI];
    logic [31:0]   m_rdata  [NI];
    logic [7:0]    m_rx     [NI];
    logic [7:0]    m_resp   [NI];
    int            m_nbytes [NI];
    logic [23:0]   m_faddr  [NI];
    logic [7:0]    mosi_log [NI][16];
    int            mosi_n   [NI];
    logic [31:0]   mw_addr  [NI][8];
    logic [31:0]   mw_data  [NI][8];
    int            mw_n     [NI];
    int            wen_n    [NI];
    int            cs_fall  [NI];
    int            cs_rise  [NI];
    int            busy_viol[NI];
    int            rd_leak  [NI];

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        spi_boot_seq_if cpu_bus ();
        spi_boot_seq_if spi_bus ();

        assign cpu_bus.wen     = cpu_wen[g];
        assign cpu_bus.addr    = cpu_addr[g];
        assign cpu_bus.wdata   = cpu_wdata[g];
        assign spi_bus.rdata   = m_rdata[g];
        assign cpu_rdata_w[g]  = cpu_bus.rdata;
        assign spi_wen_w[g]    = spi_bus.wen;
        assign spi_addr_w[g]   = spi_bus.addr;
        assign spi_wdata_w[g]  = spi_bus.wdata;

        spi_boot_seq #(
            .FLASH_BASE (24'h012345),
            .BOOT_LEN   (LEN_T[g]),
            .RAM_BASE   (32'h00000000),
            .CLK_DIV    (DIV_T[g])
        ) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .cpu       (cpu_bus),
            .spi       (spi_bus),
            .mem_wen   (mem_wen_w[g]),
            .mem_addr  (mem_addr_w[g]),
            .mem_wdata (mem_wdata_w[g]),
            .cpu_hold  (cpu_hold_w[g]),
            .boot_done (boot_done_w[g])
        );
    end

    // Flash image: bytes 0x11, 0x22 .. 0x88 at 0x012345, 0xEE elsewhere.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        logic [23:0] off;
        off = a - 24'h012345;
        if (off < 24'd8) return (off[7:0] + 8'd1) * 8'd17;
        return 8'hEE;
    endfunction

    // SPI controller + flash model: registered reads, busy for 2*(div+1) cycles per byte.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst[i]) begin
                m_cs[i] <= 1'b1;      m_busy[i] <= 1'b0;   m_cnt[i] <= 0;
                m_div[i] <= 32'd0;    m_rdata[i] <= 32'd0; m_rx[i] <= 8'd0;
                m_resp[i] <= 8'd0;    m_nbytes[i] <= 0;    m_faddr[i] <= 24'd0;
                mosi_n[i] <= 0;       mw_n[i] <= 0;        wen_n[i] <= 0;
                cs_fall[i] <= 0;      cs_rise[i] <= 0;     busy_viol[i] <= 0;
                rd_leak[i] <= 0;
            end else begin
                case (spi_addr_w[i])
                    32'd4:   m_rdata[i] <= m_div[i];
                    32'd8:   m_rdata[i] <= {24'h0, m_rx[i]};
                    32'd12:  m_rdata[i] <= {31'h0, m_busy[i]};
                    32'd16:  m_rdata[i] <= {31'h0, m_cs[i]};
                    default: m_rdata[i] <= 32'd0;
                endcase
                if (m_busy[i]) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    if (m_cnt[i] == 1) begin
                        m_busy[i] <= 1'b0;
                        m_rx[i]   <= m_resp[i];
                    end
                end
                if (spi_wen_w[i]) begin
                    wen_n[i] <= wen_n[i] + 1;
                    case (spi_addr_w[i])
                        32'd0: begin
                            if (m_busy[i]) busy_viol[i] <= busy_viol[i] + 1;
                            if (mosi_n[i] < 16) mosi_log[i][mosi_n[i]] <= spi_wdata_w[i][7:0];
                            mosi_n[i]   <= mosi_n[i] + 1;
                            m_busy[i]   <= 1'b1;
                            m_cnt[i]    <= 2 * (int'(m_div[i]) + 1);
                            m_nbytes[i] <= m_nbytes[i] + 1;
                            if (m_nbytes[i] == 1) m_faddr[i][23:16] <= spi_wdata_w[i][7:0];
                            if (m_nbytes[i] == 2) m_faddr[i][15:8]  <= spi_wdata_w[i][7:0];
                            if (m_nbytes[i] == 3) m_faddr[i][7:0]   <= spi_wdata_w[i][7:0];
                            m_resp[i] <= (m_nbytes[i] >= 4) ?
                                         flash_byte(m_faddr[i] + 24'(m_nbytes[i] - 4)) : 8'h00;
                        end
                        32'd4: m_div[i] <= spi_wdata_w[i];
                        32'd16: begin
                            if (m_cs[i] && !spi_wdata_w[i][0]) begin
                                cs_fall[i]  <= cs_fall[i] + 1;
                                m_nbytes[i] <= 0;
                            end
                            if (!m_cs[i] && spi_wdata_w[i][0]) cs_rise[i] <= cs_rise[i] + 1;
                            m_cs[i] <= spi_wdata_w[i][0];
                        end
                        default: ;
                    endcase
                end
                if (mem_wen_w[i]) begin
                    if (mw_n[i] < 8) begin
                        mw_addr[i][mw_n[i]] <= mem_addr_w[i];
                        mw_data[i][mw_n[i]] <= mem_wdata_w[i];
                    end
                    mw_n[i] <= mw_n[i] + 1;
                end
                if (!boot_done_w[i] && cpu_rdata_w[i] != 32'd0) rd_leak[i] <= rd_leak[i] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_mosi [12];
    int cyc;

    initial begin
        checks = 0;
        errors = 0;
        exp_mosi = '{8'h03, 8'h01, 8'h23, 8'h45, 8'hFF, 8'hFF,
                     8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        rst = '1;
        for (int i = 0; i < NI; i++) begin
            cpu_wen[i] = 1'b0; cpu_addr[i] = 32'd0; cpu_wdata[i] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);

        chk("rst_spi_wen",   32'(spi_wen_w[0]),   32'd0);
        chk("rst_spi_addr",  spi_addr_w[0],       32'd0);
        chk("rst_spi_wdata", spi_wdata_w[0],      32'd0);
        chk("rst_mem_wen",   32'(mem_wen_w[0]),   32'd0);
        chk("rst_mem_addr",  mem_addr_w[0],       32'd0);
        chk("rst_mem_wdata", mem_wdata_w[0],      32'd0);
        chk("rst_cpu_hold",  32'(cpu_hold_w[0]),  32'd1);
        chk("rst_boot_done", 32'(boot_done_w[0]), 32'd0);

        // Release reset; the CPU tries to drop CS on instance 0 before the port is handed over.
        rst = '0;
        cpu_wen[0] = 1'b1; cpu_addr[0] = 32'd16; cpu_wdata[0] = 32'd0;
        #1;
        chk("zl_div_wen",   32'(spi_wen_w[2]), 32'd1);
        chk("zl_div_addr",  spi_addr_w[2],     32'd4);
        chk("zl_div_data",  spi_wdata_w[2],    32'd1);
        chk("own_seq_addr", spi_addr_w[0],     32'd4);
        @(negedge clk);
        cpu_wen[0] = 1'b0; cpu_addr[0] = 32'd0;
        #1;
        chk("own_cs_held",  32'(m_cs[0]),        32'd1);
        chk("zl_done_c2",   32'(boot_done_w[2]), 32'd0);
        @(negedge clk);
        #1;
        chk("zl_done_c3",   32'(boot_done_w[2]), 32'd1);
        chk("zl_hold_c3",   32'(cpu_hold_w[2]),  32'd0);

        // Reset instance 3 once its second data byte has been shifted.
        cyc = 0;
        while (!(mosi_n[3] >= 6 && !m_busy[3]) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_trigger", 32'(cyc < 3000), 32'd1);
        rst[3] = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_spi_wen",   32'(spi_wen_w[3]),   32'd0);
        chk("mid_spi_addr",  spi_addr_w[3],       32'd0);
        chk("mid_spi_wdata", spi_wdata_w[3],      32'd0);
        chk("mid_mem_wen",   32'(mem_wen_w[3]),   32'd0);
        chk("mid_mem_addr",  mem_addr_w[3],       32'd0);
        chk("mid_cpu_hold",  32'(cpu_hold_w[3]),  32'd1);
        chk("mid_boot_done", 32'(boot_done_w[3]), 32'd0);
        @(negedge clk);
        rst[3] = 1'b0;

        cyc = 0;
        while (!(boot_done_w[0] && boot_done_w[1] && boot_done_w[2] && boot_done_w[3])
               && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        chk("all_done", 32'(cyc < 6000), 32'd1);

        chk("s1_mosi_n", 32'(mosi_n[0]), 32'd12);
        for (int b = 0; b < 12; b++) begin
            chk($sformatf("s1_mosi_%0d", b), {24'h0, mosi_log[0][b]}, {24'h0, exp_mosi[b]});
        end
        chk("s1_mw_n",     32'(mw_n[0]),       32'd2);
        chk("s1_mw0_addr", mw_addr[0][0],      32'h0);
        chk("s1_mw0_data", mw_data[0][0],      32'h44332211);
        chk("s1_mw1_addr", mw_addr[0][1],      32'h4);
        chk("s1_mw1_data", mw_data[0][1],      32'h88776655);
        chk("s1_cs_fall",  32'(cs_fall[0]),    32'd1);
        chk("s1_cs_rise",  32'(cs_rise[0]),    32'd1);
        chk("s1_cs_high",  32'(m_cs[0]),       32'd1);
        chk("s1_hold",     32'(cpu_hold_w[0]), 32'd0);
        chk("s1_div",      m_div[0],           32'd5);
        chk("busy_viol0",  32'(busy_viol[0]),  32'd0);
        chk("busy_viol1",  32'(busy_viol[1]),  32'd0);
        chk("own_rd_leak", 32'(rd_leak[0]),    32'd0);

        chk("s2_mosi_n",   32'(mosi_n[1]),     32'd9);
        chk("s2_mw_n",     32'(mw_n[1]),       32'd2);
        chk("s2_mw0_data", mw_data[1][0],      32'h44332211);
        chk("s2_mw1_addr", mw_addr[1][1],      32'h4);
        chk("s2_mw1_data", mw_data[1][1],      32'h00000055);

        chk("zl_wen_n",    32'(wen_n[2]),      32'd1);
        chk("zl_cs_fall",  32'(cs_fall[2]),    32'd0);
        chk("zl_cs_rise",  32'(cs_rise[2]),    32'd0);

        chk("mid_mw_n",     32'(mw_n[3]),      32'd2);
        chk("mid_mw0_addr", mw_addr[3][0],     32'h0);
        chk("mid_mw0_data", mw_data[3][0],     32'h44332211);
        chk("mid_mw1_addr", mw_addr[3][1],     32'h4);
        chk("mid_mw1_data", mw_data[3][1],     32'h88776655);

        // After handover the CPU owns the port: write divider 7, read it back.
        @(negedge clk);
        cpu_wen[0] = 1'b1; cpu_addr[0] = 32'd4; cpu_wdata[0] = 32'd7;
        #1;
        chk("own_pass_wen",  32'(spi_wen_w[0]), 32'd1);
        chk("own_pass_addr", spi_addr_w[0],     32'd4);
        @(negedge clk);
        cpu_wen[0] = 1'b0; cpu_wdata[0] = 32'd0;
        @(negedge clk);
        #1;
        chk("own_readback",  cpu_rdata_w[0],    32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
